// File: rtl/word_serializer_pkg.sv
// Shared state encoding and word geometry for the word serializer.
// The PARITY encoding is reserved even when WORD_SERIALIZER_PARITY_EN is not defined.
package word_serializer_pkg;

   localparam int WORD_W    = 8;
   localparam int BIT_IDX_W = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/word_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Asserting restart forces the count back to zero so a new state starts a full period.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial framer: start bit, 8 data bits in selectable order, stop bit.
// Define WORD_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              msb_first,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   state_t                 state, state_next;
   logic [WORD_W-1:0]      data, data_next;
   logic                   msb, msb_next;
   logic [BIT_IDX_W-1:0]   idx, idx_next;
   logic                   tx_next;
   logic                   done_next;
   logic                   tick;
   logic                   restart;

   function automatic logic pick_bit(input logic [WORD_W-1:0] w,
                                     input logic m,
                                     input logic [BIT_IDX_W-1:0] i);
      return m ? w[BIT_IDX_W'(WORD_W - 1) - i] : w[i];
   endfunction

   assign din_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign restart   = (state_next != state);

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_next = state;
      data_next  = data;
      msb_next   = msb;
      idx_next   = idx;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (din_valid) begin
               state_next = START;
               data_next  = din;
               msb_next   = msb_first;
               idx_next   = '0;
            end
         end
         START: begin
            if (tick) begin
               state_next = DATA;
               idx_next   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               idx_next = idx + BIT_IDX_W'(1);
               if (idx == BIT_IDX_W'(WORD_W - 1)) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef WORD_SERIALIZER_PARITY_EN
         PARITY: begin
            if (tick) state_next = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // tx is registered, so it is driven from the state being entered
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = pick_bit(data_next, msb_next, idx_next);
`ifdef WORD_SERIALIZER_PARITY_EN
         PARITY:  tx_next = ^data_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         data  <= '0;
         msb   <= 1'b0;
         idx   <= '0;
         tx    <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         data  <= data_next;
         msb   <= msb_next;
         idx   <= idx_next;
         tx    <= tx_next;
         done  <= done_next;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (CLKS_PER_BIT=4) with a frame scoreboard.
// Parity scenarios are compiled in when WORD_SERIALIZER_PARITY_EN is defined.
module tb_word_serializer;

   localparam int CPB = 4;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int N = NB * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       msb_first;
   logic       tx;
   logic       busy;
   logic       done;

   typedef struct {
      logic [15:0] bits;
      logic [7:0]  word;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   word_serializer #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .msb_first (msb_first),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   // Expected line bits, one entry per bit period; unused upper entries stay high.
   function automatic logic [15:0] model(input logic [7:0] w, input logic m);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = m ? w[7 - i] : w[i];
`ifdef WORD_SERIALIZER_PARITY_EN
      f[9] = ^w;
`endif
      return f;
   endfunction

   task automatic send(input logic [7:0] w, input logic m, output logic ok);
      int t;
      t = 0;
      @(negedge clk);
      while (din_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (din_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready: din_ready=%b required 1", din_ready);
         ok = 1'b0;
         return;
      end
      ok        = 1'b1;
      din       = w;
      msb_first = m;
      din_valid = 1'b1;
      sb.push_back('{model(w, m), w});
   endtask

   // Samples N+1 cycles starting the cycle after the accepting edge; sample N is the done cycle.
   task automatic capture(input logic drop, input logic upd, input logic [7:0] nd,
                          output logic [15:0] bits, output logic stable,
                          output int busy_cnt, output int done_at, output int done_cnt,
                          output logic tx_n, output logic rdy_n);
      bits = '1; stable = 1'b1; busy_cnt = 0; done_at = -1; done_cnt = 0;
      tx_n = 1'bx; rdy_n = 1'bx;
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i < N) begin
            if (i % CPB == 0) bits[i / CPB] = tx;
            else if (tx !== bits[i / CPB]) stable = 1'b0;
            if (busy === 1'b1) busy_cnt++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (i == N) begin
            tx_n  = tx;
            rdy_n = din_ready;
         end
         if (i == 0) begin
            if (drop) begin
               din_valid = 1'b0;
               din       = 8'($urandom);
            end
            if (upd) din = ~nd;
         end
         if (i == N / 2 && upd) din = nd;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; din = 8'h55; din_valid = 1'b1; msb_first = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: tx=%b required 1", tx); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%b required 0", busy); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: done=%b required 0", done); end
         checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: din_ready=%b required 1", din_ready); end
      end
      din_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: busy=%b required 0", busy); end
   endtask

   task automatic test_lsb_first();
      logic ok, stable, tx_n, rdy_n; logic [15:0] bits; int bc, da, dc; exp_t e;
      send(8'hCC, 1'b0, ok);
      if (!ok) return;
      capture(1'b1, 1'b0, 8'h00, bits, stable, bc, da, dc, tx_n, rdy_n);
      e = sb.pop_front();
      checks++; if (bits !== e.bits) begin errors++; $display("FAIL lsb_frame: got %h required %h", bits, e.bits); end
      checks++; if (bits[8:1] !== 8'hCC) begin errors++; $display("FAIL lsb_data: got %h required cc", bits[8:1]); end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL lsb_stable: got %b required 1", stable); end
      checks++; if (da != N) begin errors++; $display("FAIL lsb_done_at: got %0d required %0d", da, N); end
      checks++; if (dc != 1) begin errors++; $display("FAIL lsb_done_cnt: got %0d required 1", dc); end
      checks++; if (tx_n !== 1'b1 || rdy_n !== 1'b1) begin errors++; $display("FAIL lsb_idle: tx=%b ready=%b required 1 1", tx_n, rdy_n); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL lsb_done_pulse: done=%b required 0", done); end
   endtask

   task automatic test_msb_first();
      logic ok, stable, tx_n, rdy_n; logic [15:0] bits; int bc, da, dc; exp_t e;
      send(8'hAA, 1'b1, ok);
      if (!ok) return;
      capture(1'b1, 1'b0, 8'h00, bits, stable, bc, da, dc, tx_n, rdy_n);
      e = sb.pop_front();
      checks++; if (bits !== e.bits) begin errors++; $display("FAIL msb_frame: got %h required %h", bits, e.bits); end
      checks++; if (bits[8:1] !== 8'h55) begin errors++; $display("FAIL msb_data: got %h required 55", bits[8:1]); end
      checks++; if (bc != N) begin errors++; $display("FAIL msb_busy: got %0d required %0d", bc, N); end
      checks++; if (stable !== 1'b1 || da != N) begin errors++; $display("FAIL msb_timing: stable=%b done_at=%0d required 1 %0d", stable, da, N); end
   endtask

`ifdef WORD_SERIALIZER_PARITY_EN
   task automatic test_parity();
      logic ok, stable, tx_n, rdy_n; logic [15:0] bits; int bc, da, dc; exp_t e;
      logic [7:0] words [2];
      logic       pars [2];
      words[0] = 8'hE0; pars[0] = 1'b1;
      words[1] = 8'h03; pars[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         send(words[k], 1'b0, ok);
         if (!ok) return;
         capture(1'b1, 1'b0, 8'h00, bits, stable, bc, da, dc, tx_n, rdy_n);
         e = sb.pop_front();
         checks++; if (bits !== e.bits) begin errors++; $display("FAIL par_frame: got %h required %h", bits, e.bits); end
         checks++; if (bits[9] !== pars[k]) begin errors++; $display("FAIL par_bit: got %b required %b", bits[9], pars[k]); end
         checks++; if (bc != 44 || da != 44) begin errors++; $display("FAIL par_len: busy=%0d done_at=%0d required 44 44", bc, da); end
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic ok, s1, s2, tx1, rd1, tx2, rd2; logic [15:0] b1, b2; int bc1, da1, dc1, bc2, da2, dc2; exp_t e;
      send(8'h01, 1'b0, ok);
      if (!ok) return;
      capture(1'b0, 1'b1, 8'h80, b1, s1, bc1, da1, dc1, tx1, rd1);
      e = sb.pop_front();
      checks++; if (b1 !== e.bits) begin errors++; $display("FAIL b2b_frame1: got %h required %h", b1, e.bits); end
      checks++; if (tx1 !== 1'b1 || rd1 !== 1'b1 || da1 != N) begin errors++; $display("FAIL b2b_gap: tx=%b ready=%b done_at=%0d required 1 1 %0d", tx1, rd1, da1, N); end
      sb.push_back('{model(8'h80, 1'b0), 8'h80});
      capture(1'b1, 1'b0, 8'h00, b2, s2, bc2, da2, dc2, tx2, rd2);
      e = sb.pop_front();
      checks++; if (b2 !== e.bits) begin errors++; $display("FAIL b2b_frame2: got %h required %h", b2, e.bits); end
      checks++; if (bc2 != N || da2 != N || s2 !== 1'b1) begin errors++; $display("FAIL b2b_timing2: busy=%0d done_at=%0d stable=%b required %0d %0d 1", bc2, da2, s2, N, N); end
   endtask

   task automatic test_abort();
      logic ok, stable, tx_n, rdy_n; logic [15:0] bits; int bc, da, dc, dcount; exp_t e;
      send(8'hFF, 1'b0, ok);
      if (!ok) return;
      void'(sb.pop_back());
      for (int i = 0; i < 18; i++) @(negedge clk);
      din_valid = 1'b0;
      checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL abort_pre: busy=%b tx=%b required 1 1", busy, tx); end
      reset = 1'b0;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || din_ready !== 1'b1) begin
         errors++; $display("FAIL abort_async: tx=%b busy=%b done=%b ready=%b required 1 0 0 1", tx, busy, done, din_ready);
      end
      repeat (3) @(negedge clk);
      reset  = 1'b1;
      dcount = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      checks++; if (dcount != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", dcount); end
      send(8'h5A, 1'b0, ok);
      if (!ok) return;
      capture(1'b1, 1'b0, 8'h00, bits, stable, bc, da, dc, tx_n, rdy_n);
      e = sb.pop_front();
      checks++; if (bits !== e.bits || stable !== 1'b1) begin errors++; $display("FAIL abort_next_frame: got %h stable=%b required %h 1", bits, stable, e.bits); end
      checks++; if (da != N || dc != 1) begin errors++; $display("FAIL abort_next_done: done_at=%0d count=%0d required %0d 1", da, dc, N); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lsb_first();
      test_msb_first();
`ifdef WORD_SERIALIZER_PARITY_EN
      test_parity();
`endif
      test_back_to_back();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
